// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles.
// Reports on each detected rising edge; flags a stall when no edge arrives for MAX cycles.
module period_meter #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stalled,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        STALL
    } state_t;

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] hcnt, hcnt_next;
    logic [CNT_W-1:0] period_next, high_time_next;
    logic             valid_next, stalled_next, locked_next;

    // s1/s2 resolve metastability; s3 keeps the previous s2 for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            hcnt      <= hcnt_next;
            period    <= period_next;
            high_time <= high_time_next;
            valid     <= valid_next;
            stalled   <= stalled_next;
            locked    <= locked_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        hcnt_next      = hcnt;
        period_next    = period;
        high_time_next = high_time;
        valid_next     = 1'b0;
        stalled_next   = stalled;
        locked_next    = locked;

        case (state)
            IDLE: begin
                if (rise) begin
                    cnt_next   = ONE;
                    hcnt_next  = ONE;
                    state_next = MEAS;
                end
            end

            MEAS: begin
                // A rise on the saturated count still reports, so a period of exactly MAX is measurable
                if (rise) begin
                    period_next    = cnt;
                    high_time_next = hcnt;
                    valid_next     = 1'b1;
                    locked_next    = (cnt == period) && (period != '0);
                    cnt_next       = ONE;
                    hcnt_next      = ONE;
                end else begin
                    if (cnt != MAX) begin
                        cnt_next = cnt + ONE;
                    end
                    if (s2 && (hcnt != MAX)) begin
                        hcnt_next = hcnt + ONE;
                    end
                    if (cnt == MAX) begin
                        state_next   = STALL;
                        stalled_next = 1'b1;
                        locked_next  = 1'b0;
                    end
                end
            end

            STALL: begin
                // The interval that ended here is unknown, so restart without reporting
                if (rise) begin
                    stalled_next = 1'b0;
                    cnt_next     = ONE;
                    hcnt_next    = ONE;
                    state_next   = MEAS;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
// Randomized scoreboard bench for period_meter: a sample-level reference model
// predicts reports and stall transitions, a negedge monitor compares them.
module tb_period_meter;

    localparam int CNT_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             stalled;
    logic             locked;

    period_meter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stalled   (stalled),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int per;
        int hi;
        bit lk;
    } rep_t;

    typedef struct {
        int cyc;
        bit lvl;
    } stl_t;

    rep_t repQ[$];
    stl_t stlQ[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: works on sampled input levels, one per clock edge
    bit prevLvl    = 1'b0;
    bit haveRise   = 1'b0;
    bit stalledM   = 1'b0;
    int lastRise   = 0;
    int highCount  = 0;
    int lastPeriod = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Drive one sample; it is captured at edge k and any consequence appears at edge k+2
    task automatic applyStimulus(input logic lvl);
        int k;
        rep_t r;
        stl_t s;
        k = cyc + 1;
        sig_in = lvl;
        if (lvl && !prevLvl) begin
            if (stalledM) begin
                s.cyc = k + 2;
                s.lvl = 1'b0;
                stlQ.push_back(s);
                stalledM = 1'b0;
            end else if (haveRise) begin
                r.cyc = k + 2;
                r.per = k - lastRise;
                r.hi  = highCount;
                r.lk  = (r.per == lastPeriod) && (lastPeriod != 0);
                repQ.push_back(r);
                lastPeriod = r.per;
            end
            haveRise  = 1'b1;
            lastRise  = k;
            highCount = 1;
        end else if (haveRise && !stalledM) begin
            if (lvl) highCount++;
            if (k - lastRise == MAX) begin
                s.cyc = k + 2;
                s.lvl = 1'b1;
                stlQ.push_back(s);
                stalledM = 1'b1;
            end
        end
        prevLvl = lvl;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        repeat (h) applyStimulus(1'b1);
        repeat (l) applyStimulus(1'b0);
    endtask

    task automatic resetDut();
        #2;
        rst = 1'b1;
        repQ.delete();
        stlQ.delete();
        #1;
        checkOutput("reset_period", period, 0);
        checkOutput("reset_high_time", high_time, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_stalled", stalled, 0);
        checkOutput("reset_locked", locked, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prevLvl    = 1'b0;
        haveRise   = 1'b0;
        stalledM   = 1'b0;
        highCount  = 0;
        lastPeriod = 0;
    endtask

    // Monitor: independent of stimulus, consumes expectations as their cycle comes up
    bit   expStalled = 1'b0;
    bit   expValid;
    rep_t cur;
    stl_t st;

    always @(negedge clk) begin
        if (rst) begin
            expStalled = 1'b0;
        end else begin
            while (stlQ.size() > 0 && stlQ[0].cyc <= cyc) begin
                st = stlQ.pop_front();
                expStalled = st.lvl;
                if (st.lvl) checkOutput("locked_at_stall", locked, 0);
            end
            checkOutput("stalled", stalled, expStalled);
            expValid = 1'b0;
            while (repQ.size() > 0 && repQ[0].cyc < cyc) void'(repQ.pop_front());
            if (repQ.size() > 0 && repQ[0].cyc == cyc) begin
                cur = repQ.pop_front();
                expValid = 1'b1;
                checkOutput("period", period, cur.per);
                checkOutput("high_time", high_time, cur.hi);
                checkOutput("locked", locked, cur.lk);
            end
            checkOutput("valid", valid, expValid);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h, l;
        $display("[TB] starting period_meter bench, CNT_W=%0d", CNT_W);
        resetDut();

        // Steady 5/5 square wave, then a period change to 7/5
        repeat (6) pulse(5, 5);
        repeat (4) pulse(7, 5);

        // Random steady waves, each held for three periods so lock can be seen
        repeat (8) begin
            h = $urandom_range(1, 20);
            l = $urandom_range(1, 40);
            repeat (3) pulse(h, l);
        end

        // Narrow pulses
        repeat (4) pulse(1, 19);

        // Rises exactly MAX apart: report MAX, never stall
        repeat (3) pulse(1, MAX - 1);

        // Stall, recovery without report, then a true period
        pulse(3, 300);
        repeat (3) pulse(5, 5);

        // Reset mid-measurement with the input high across release
        repeat (3) pulse(4, 6);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        resetDut();
        repeat (4) pulse(4, 6);

        // Random level stream
        repeat (200) applyStimulus(logic'($urandom_range(0, 1)));
        repeat (3) pulse(5, 5);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("pending_reports", repQ.size(), 0);
        checkOutput("pending_stall_events", stlQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
